sram_arbiter: RTL and testbench

Two-to-one arbiter that shares a single SRAM-like memory port between the CPU's instruction-fetch requester and data-access requester. It sits between the pipeline and the single cache/AXI bridge port. It sequences one transaction at a time: arbitrate, issue the address, wait for data, then route the response to its owner. Data requests have priority, and a starvation guard guarantees forward progress for instruction fetch.

---
 rtl/arb_pkg.sv | 18 +
 rtl/wstrb_gen.sv | 22 ++
 rtl/sram_arbiter.sv | 151 +++++++++++++++
 tb/tb_sram_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared encodings for the two-to-one SRAM-like port arbiter.
package arb_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnInst = 2'd1,
        OwnData = 2'd2
    } owner_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/wstrb_gen.sv
// Byte-strobe decode from access size and low address bits; reads yield no strobes.
module wstrb_gen
    import arb_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    input  logic       wr,
    output logic [3:0] wstrb
);

    always_comb begin
        wstrb = 4'b0000;
        if (wr) begin
            case (size)
                SIZE_B:  wstrb = 4'b0001 << addr_lo;
                SIZE_H:  wstrb = 4'b0011 << {addr_lo[1], 1'b0};
                default: wstrb = 4'b1111;
            endcase
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data access, one transaction
// at a time; data has priority, bounded by a starvation guard for instruction fetch.
module sram_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    logic [1:0]      state_q, state_d;
    owner_e          owner_q, owner_d;
    logic [CntW-1:0] starve_q, starve_d;
    logic            hold_wr_q, hold_wr_d;
    logic [1:0]      hold_size_q, hold_size_d;
    logic [31:0]     hold_addr_q, hold_addr_d;
    logic [31:0]     hold_wdata_q, hold_wdata_d;
    logic            grant_data;
    logic            in_req;
    logic            in_wait;
    logic [3:0]      wstrb;

    wstrb_gen u_wstrb_gen (
        .size    (hold_size_q),
        .addr_lo (hold_addr_q[1:0]),
        .wr      (hold_wr_q),
        .wstrb   (wstrb)
    );

    // Data wins unless instruction fetch has already waited out the full limit.
    assign grant_data = data_req && !(inst_req && (starve_q == Limit));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_d     = starve_q;
        hold_wr_d    = hold_wr_q;
        hold_size_d  = hold_size_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        case (state_q)
            StIdle: begin
                if (grant_data) begin
                    state_d      = StReq;
                    owner_d      = OwnData;
                    hold_wr_d    = data_wr;
                    hold_size_d  = data_size;
                    hold_addr_d  = data_addr;
                    hold_wdata_d = data_wdata;
                    if (!inst_req) begin
                        starve_d = '0;
                    end else if (starve_q != Limit) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (inst_req) begin
                    state_d      = StReq;
                    owner_d      = OwnInst;
                    hold_wr_d    = 1'b0;
                    hold_size_d  = SIZE_W;
                    hold_addr_d  = inst_addr;
                    hold_wdata_d = '0;
                    starve_d     = '0;
                end
            end
            StReq: begin
                if (mem_addr_ok) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_data_ok) begin
                    state_d = StIdle;
                    owner_d = OwnNone;
                end
            end
            default: begin
                state_d = StIdle;
                owner_d = OwnNone;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StIdle;
            owner_q      <= OwnNone;
            starve_q     <= '0;
            hold_wr_q    <= 1'b0;
            hold_size_q  <= '0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_q     <= starve_d;
            hold_wr_q    <= hold_wr_d;
            hold_size_q  <= hold_size_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
        end
    end

    assign in_req  = (state_q == StReq);
    assign in_wait = (state_q == StWait);

    // The memory port is driven only while a request is being presented.
    always_comb begin
        mem_req   = in_req;
        mem_wr    = in_req & hold_wr_q;
        mem_size  = in_req ? hold_size_q : 2'b00;
        mem_wstrb = in_req ? wstrb : 4'b0000;
        mem_addr  = in_req ? hold_addr_q : 32'h0;
        mem_wdata = in_req ? hold_wdata_q : 32'h0;
    end

    always_comb begin
        inst_addr_ok = in_req && mem_addr_ok && (owner_q == OwnInst);
        data_addr_ok = in_req && mem_addr_ok && (owner_q == OwnData);
        inst_data_ok = in_wait && mem_data_ok && (owner_q == OwnInst);
        data_data_ok = in_wait && mem_data_ok && (owner_q == OwnData);
        inst_rdata   = (owner_q == OwnInst) ? mem_rdata : 32'h0;
        data_rdata   = (owner_q == OwnData) ? mem_rdata : 32'h0;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: requester tasks queue expected transactions,
// a monitor checks the memory port and responses as the DUT presents them.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    sram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } exp_t;

    exp_t        inst_q[$];
    exp_t        data_q[$];
    logic [31:0] mem_model [logic [31:0]];
    string       got_order = "";
    int          n_checks = 0;
    int          n_fail = 0;
    int          addr_dly = 0;
    int          data_dly = 0;
    int          rsp_state = 0;
    int          rsp_cnt = 0;
    logic [31:0] rsp_addr = '0;

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_order(input string name, input string exp);
        n_checks++;
        if (got_order != exp) begin
            n_fail++;
            $display("FAIL %s: grant order %s, expected %s", name, got_order, exp);
        end
    endtask

    task automatic chk_outs_zero(input string name);
        chk({name, "_mem"}, {mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, '0);
        chk({name, "_cpu"}, {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
                             inst_rdata, data_rdata}, '0);
    endtask

    // Memory responder: acks addr_dly cycles into REQ, returns data data_dly cycles into WAIT.
    initial begin
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
            mem_rdata   = '0;
            if (rsp_state == 0 && mem_req) begin
                if (rsp_cnt == addr_dly) begin
                    mem_addr_ok = 1'b1;
                    rsp_addr    = mem_addr;
                    rsp_state   = 1;
                    rsp_cnt     = 0;
                end else begin
                    rsp_cnt++;
                end
            end else if (rsp_state == 1) begin
                if (rsp_cnt == data_dly) begin
                    mem_data_ok = 1'b1;
                    mem_rdata   = mem_model.exists(rsp_addr) ? mem_model[rsp_addr] : 32'hDEAD_BEEF;
                    rsp_state   = 0;
                    rsp_cnt     = 0;
                end else begin
                    rsp_cnt++;
                end
            end
        end
    end

    // Monitor
    initial begin
        logic        prev_req;
        logic        prev_acc;
        logic [70:0] snap;
        exp_t        e;
        prev_req = 1'b0;
        prev_acc = 1'b0;
        snap     = '0;
        forever begin
            @(negedge clk);
            if (mem_req && prev_req)
                chk("mem_stable_in_req", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, snap);
            if (prev_acc)
                chk("mem_req_low_in_wait", mem_req, 1'b0);
            if (inst_addr_ok || data_addr_ok)
                chk("addr_ok_onehot", inst_addr_ok & data_addr_ok, 1'b0);
            if (inst_data_ok || data_data_ok)
                chk("data_ok_onehot", inst_data_ok & data_data_ok, 1'b0);

            if (inst_addr_ok) begin
                got_order = {got_order, "I"};
                chk("inst_addr_ok_src", {mem_req, mem_addr_ok}, 2'b11);
                chk("inst_addr_ok_pending", inst_q.size() != 0, 1'b1);
                if (inst_q.size() != 0) begin
                    e = inst_q[0];
                    chk("inst_mem_fields", {mem_wr, mem_size, mem_wstrb, mem_addr},
                        {e.wr, e.size, e.wstrb, e.addr});
                end
            end
            if (data_addr_ok) begin
                got_order = {got_order, "D"};
                chk("data_addr_ok_src", {mem_req, mem_addr_ok}, 2'b11);
                chk("data_addr_ok_pending", data_q.size() != 0, 1'b1);
                if (data_q.size() != 0) begin
                    e = data_q[0];
                    chk("data_mem_fields", {mem_wr, mem_size, mem_wstrb, mem_addr},
                        {e.wr, e.size, e.wstrb, e.addr});
                    if (e.wr) chk("data_mem_wdata", mem_wdata, e.wdata);
                end
            end
            if (inst_data_ok) begin
                chk("inst_data_ok_pending", inst_q.size() != 0, 1'b1);
                chk("data_side_quiet", {data_data_ok, data_rdata}, '0);
                if (inst_q.size() != 0) begin
                    e = inst_q.pop_front();
                    chk("inst_rdata", inst_rdata, e.rdata);
                end
            end
            if (data_data_ok) begin
                chk("data_data_ok_pending", data_q.size() != 0, 1'b1);
                chk("inst_side_quiet", {inst_data_ok, inst_rdata}, '0);
                if (data_q.size() != 0) begin
                    e = data_q.pop_front();
                    if (!e.wr) chk("data_rdata", data_rdata, e.rdata);
                end
            end
            prev_req = mem_req;
            prev_acc = mem_req && mem_addr_ok;
            snap     = {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata};
        end
    end

    task automatic inst_txn(input logic [31:0] addr, input logic [31:0] rd);
        exp_t e;
        int   t;
        e.addr = addr; e.wr = 1'b0; e.size = 2'd2; e.wdata = '0; e.wstrb = 4'b0000;
        e.rdata = rd;
        mem_model[addr] = rd;
        inst_q.push_back(e);
        inst_req  = 1'b1;
        inst_addr = addr;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!inst_addr_ok && t < 200);
        chk("inst_accept", inst_addr_ok, 1'b1);
        @(posedge clk);
        #1;
        inst_req = 1'b0;
    endtask

    task automatic data_txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb,
                            input logic [31:0] rd);
        exp_t e;
        int   t;
        e.addr = addr; e.wr = wr; e.size = size; e.wdata = wdata; e.wstrb = wstrb;
        e.rdata = rd;
        if (!wr) mem_model[addr] = rd;
        data_q.push_back(e);
        data_req   = 1'b1;
        data_wr    = wr;
        data_size  = size;
        data_addr  = addr;
        data_wdata = wdata;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!data_addr_ok && t < 200);
        chk("data_accept", data_addr_ok, 1'b1);
        @(posedge clk);
        #1;
        data_req = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((inst_q.size() != 0 || data_q.size() != 0 || rsp_state != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({"drain_", name}, {inst_q.size() != 0, data_q.size() != 0, rsp_state != 0}, '0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0; data_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outs_zero("reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Single fetch with immediate memory acks: addr_ok in cycle 2, data_ok in cycle 3.
        fork
            inst_txn(32'hBFC0_0000, 32'h2401_0001);
            begin
                @(negedge clk); chk("fetch_c1_addr_ok", inst_addr_ok, 1'b0);
                @(negedge clk); chk("fetch_c2_addr_ok", inst_addr_ok, 1'b1);
                @(negedge clk); chk("fetch_c3_data_ok", inst_data_ok, 1'b1);
                chk("fetch_c3_rdata", inst_rdata, 32'h2401_0001);
            end
        join
        drain("fetch");

        data_txn(1'b1, 2'd0, 32'h0000_1003, 32'hABAB_ABAB, 4'b1000, '0); drain("byte3");
        data_txn(1'b1, 2'd1, 32'h0000_1002, 32'hCDEF_CDEF, 4'b1100, '0); drain("half2");
        data_txn(1'b1, 2'd0, 32'h0000_1001, 32'h1212_1212, 4'b0010, '0); drain("byte1");
        data_txn(1'b1, 2'd1, 32'h0000_1000, 32'h3434_3434, 4'b0011, '0); drain("half0");
        data_txn(1'b1, 2'd3, 32'h0000_1004, 32'h5566_7788, 4'b1111, '0); drain("size3");
        data_txn(1'b0, 2'd2, 32'h0000_2000, '0, 4'b0000, 32'hCAFE_F00D); drain("read");

        got_order = "";
        fork
            data_txn(1'b0, 2'd2, 32'h0000_2004, '0, 4'b0000, 32'h0BAD_C0DE);
            inst_txn(32'hBFC0_0004, 32'h3C1D_0001);
        join
        drain("collision");
        chk_order("collision_order", "DI");

        got_order = "";
        fork
            for (int i = 0; i < 2; i++)
                inst_txn(32'hBFC0_0100 + 32'(i * 4), 32'h1000_0000 + 32'(i));
            for (int j = 0; j < 8; j++)
                data_txn(1'b0, 2'd2, 32'h0000_3000 + 32'(j * 4), '0, 4'b0000,
                         32'h2000_0000 + 32'(j));
        join
        drain("starve");
        chk_order("starve_order", "DDDDIDDDDI");

        // Slow memory while inst_req rises mid-REQ.
        addr_dly = 5;
        data_dly = 7;
        got_order = "";
        fork
            data_txn(1'b0, 2'd2, 32'h0000_5000, '0, 4'b0000, 32'h5A5A_A5A5);
            begin
                repeat (2) @(posedge clk);
                #1;
                inst_txn(32'hBFC0_0200, 32'h0000_0200);
            end
        join
        drain("delay");
        chk_order("delay_order", "DI");

        // Reset in WAIT, then a stale mem_data_ok must be ignored.
        addr_dly = 0;
        data_dly = 6;
        data_txn(1'b0, 2'd2, 32'h0000_4000, '0, 4'b0000, 32'h1111_2222);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        data_q.delete();
        @(negedge clk);
        chk_outs_zero("reset_wait");
        drain("stale");
        data_dly = 0;
        data_txn(1'b0, 2'd2, 32'h0000_4004, '0, 4'b0000, 32'h3333_4444);
        drain("after_reset_data");
        inst_txn(32'hBFC0_0300, 32'h7777_8888);
        drain("after_reset_inst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
